// File: rtl/ariane_pkg.sv
// Shared core package: D$ request/response port types, store-merge
// constants and the byte-merge helper.
package ariane_pkg;

   localparam int DCACHE_INDEX_WIDTH = 12;
   localparam int DCACHE_TAG_WIDTH   = riscv::PLEN - DCACHE_INDEX_WIDTH;

   // Idle cycles a partially merged store is held before going to the D$.
   localparam int unsigned STORE_MERGE_TIMEOUT = 8;

   // Request from a client to the D$.
   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   // Response from the D$ to a client.
   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

   // Per byte: take the new byte where its enable is set, else keep the old one.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                               input logic [63:0] new_data,
                                               input logic [7:0]  be);
      logic [63:0] res;
      res = old_data;
      for (int i = 0; i < 8; i++) begin
         if (be[i]) begin
            res[i*8 +: 8] = new_data[i*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V architectural constants used by the memory-side blocks.
package riscv;

   // Physical address width (Sv39 style physical space).
   localparam int PLEN = 56;

endpackage

// File: rtl/store_merge_unit.sv
// Store merge unit: holds one committed store, merges further stores to the
// same double-word into it, and issues the merged entry as a single D$ write
// on drain, address change, full byte mask or merge timeout.
module store_merge_unit
   import ariane_pkg::*;
#(
   parameter int unsigned MERGE_TIMEOUT = STORE_MERGE_TIMEOUT
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [riscv::PLEN-1:0] paddr_i,
   input  logic [63:0]            data_i,
   input  logic [7:0]             be_i,
   input  logic                   drain_i,
   output logic                   empty_o,
   input  logic [11:0]            page_offset_i,
   output logic                   page_offset_matches_o,
   input  dcache_req_o_t          req_port_i,
   output dcache_req_i_t          req_port_o
);

   localparam int unsigned AW    = riscv::PLEN - 3;
   localparam int unsigned CNT_W = (MERGE_TIMEOUT > 1) ? $clog2(MERGE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MERGE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      REQ   = 2'd2
   } state_e;

   state_e           r_state, w_state_next;
   logic [AW-1:0]    r_addr,  w_addr_next;
   logic [63:0]      r_data,  w_data_next;
   logic [7:0]       r_be,    w_be_next;
   logic [CNT_W-1:0] r_cnt,   w_cnt_next;

   logic             w_match;
   logic             w_merge;
   logic [7:0]       w_be_merged;
   logic             w_unused_bits;

   // An offered store hits the held double-word.
   assign w_match     = valid_i && (paddr_i[riscv::PLEN-1:3] == r_addr);
   // Drain wins over a merge: a drained cycle never accepts the store.
   assign w_merge     = (r_state == HOLD) && w_match && !drain_i;
   assign w_be_merged = r_be | be_i;

   // Byte offsets inside the dword and unused D$ response fields carry no meaning here.
   assign w_unused_bits = ^{paddr_i[2:0], page_offset_i[2:0],
                            req_port_i.data_rvalid, req_port_i.data_rdata};

   // State and held-entry registers; reset drops any entry in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= EMPTY;
         r_addr  <= '0;
         r_data  <= '0;
         r_be    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_addr  <= w_addr_next;
         r_data  <= w_data_next;
         r_be    <= w_be_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state, entry update and store-buffer handshake.
   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      w_data_next  = r_data;
      w_be_next    = r_be;
      w_cnt_next   = r_cnt;
      ready_o      = 1'b0;

      case (r_state)
         EMPTY: begin
            ready_o = 1'b1;
            if (valid_i) begin
               w_addr_next  = paddr_i[riscv::PLEN-1:3];
               w_data_next  = data_i;
               w_be_next    = be_i;
               w_cnt_next   = '0;
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            ready_o = w_merge;
            if (drain_i || (valid_i && !w_match)) begin
               w_state_next = REQ;
            end else if (w_merge) begin
               // A merge restarts the idle window, so it beats the timeout.
               w_data_next = merge_bytes(r_data, data_i, be_i);
               w_be_next   = w_be_merged;
               w_cnt_next  = '0;
               if (w_be_merged == 8'hFF) begin
                  w_state_next = REQ;
               end
            end else if ((r_be == 8'hFF) || (r_cnt == CNT_LAST)) begin
               // A full mask captured on entry leaves at once; otherwise time out.
               w_state_next = REQ;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         REQ: begin
            if (req_port_i.data_gnt) begin
               w_state_next = EMPTY;
            end
         end
         default: begin
            w_state_next = EMPTY;
         end
      endcase
   end

   // D$ write request, driven purely from the held entry so it is stable until grant.
   always_comb begin
      req_port_o = '0;
      if (r_state == REQ) begin
         req_port_o.data_req      = 1'b1;
         req_port_o.data_we       = 1'b1;
         req_port_o.tag_valid     = 1'b1;
         req_port_o.kill_req      = 1'b0;
         req_port_o.data_size     = 2'b11;
         req_port_o.data_be       = r_be;
         req_port_o.data_wdata    = r_data;
         req_port_o.address_index = {r_addr[DCACHE_INDEX_WIDTH-4:0], 3'b000};
         req_port_o.address_tag   = r_addr[AW-1:DCACHE_INDEX_WIDTH-3];
      end
   end

   assign empty_o               = (r_state == EMPTY);
   assign page_offset_matches_o = (r_state != EMPTY) && (r_addr[8:0] == page_offset_i[11:3]);

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: a per-cycle vector table for the
// merge / mismatch / hazard / drain flows plus hand sequences for timeout,
// grant stall, minimum latency and reset while a request is pending.
module tb_store_merge_unit;
   import ariane_pkg::*;

   localparam int TO = 8;
   localparam int PW = riscv::PLEN;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          valid = 1'b0;
   logic          ready;
   logic [PW-1:0] paddr = '0;
   logic [63:0]   wdata_in = '0;
   logic [7:0]    be_in = '0;
   logic          drain = 1'b0;
   logic          empty;
   logic [11:0]   poff = '0;
   logic          pmatch;
   logic          gnt = 1'b0;
   dcache_req_o_t dresp;
   dcache_req_i_t dreq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      dresp          = '0;
      dresp.data_gnt = gnt;
   end

   store_merge_unit dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .valid_i               (valid),
      .ready_o               (ready),
      .paddr_i               (paddr),
      .data_i                (wdata_in),
      .be_i                  (be_in),
      .drain_i               (drain),
      .empty_o               (empty),
      .page_offset_i         (poff),
      .page_offset_matches_o (pmatch),
      .req_port_i            (dresp),
      .req_port_o            (dreq)
   );

   typedef struct {
      logic          v;
      logic [PW-1:0] a;
      logic [63:0]   d;
      logic [7:0]    be;
      logic          dr;
      logic          g;
      logic [11:0]   po;
      logic          e_ready;
      logic          e_req;
      logic          e_empty;
      logic          e_match;
      logic [PW-1:0] e_addr;
      logic [7:0]    e_be;
      logic [63:0]   e_wdata;
   } vec_t;

   vec_t vt[34];

   function automatic vec_t mk(input logic v, input logic [PW-1:0] a, input logic [63:0] d,
                               input logic [7:0] be, input logic dr, input logic g,
                               input logic [11:0] po, input logic er, input logic eq,
                               input logic ee, input logic em, input logic [PW-1:0] ea,
                               input logic [7:0] ebe, input logic [63:0] ewd);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.be = be; r.dr = dr; r.g = g; r.po = po;
      r.e_ready = er; r.e_req = eq; r.e_empty = ee; r.e_match = em;
      r.e_addr = ea; r.e_be = ebe; r.e_wdata = ewd;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Checks every request field against the expected D$ write.
   task automatic chk_req(input string name, input logic [PW-1:0] ea,
                          input logic [7:0] ebe, input logic [63:0] ewd);
      logic [PW-1:0] addr;
      addr = {dreq.address_tag, dreq.address_index};
      chk({name, "_req"},   64'(dreq.data_req), 64'd1);
      chk({name, "_addr"},  64'(addr), 64'(ea));
      chk({name, "_be"},    64'(dreq.data_be), 64'(ebe));
      chk({name, "_wdata"}, dreq.data_wdata, ewd);
      chk({name, "_ctrl"},  64'({dreq.data_we, dreq.tag_valid, dreq.kill_req, dreq.data_size}),
          64'(5'b11011));
   endtask

   task automatic drive(input logic v, input logic [PW-1:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic dr, input logic g);
      valid = v; paddr = a; wdata_in = d; be_in = be; drain = dr; gnt = g;
   endtask

   // Counts cycles after the last acceptance edge until data_req appears, then grants it.
   task automatic wait_req(input string name, input int exp_k);
      int k;
      k = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         drive(1'b0, '0, '0, 8'h00, 1'b0, 1'b0);
         #1;
         if (dreq.data_req) begin
            k = n;
            break;
         end
      end
      chk({name, "_latency"}, 64'(k), 64'(exp_k));
      $display("seq %s: data_req after %0d cycles", name, k);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      #1;
      chk({name, "_empty"}, 64'(empty), 64'd1);
   endtask

   initial begin
      // merge of two half-dwords into one full write
      vt[0]  = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[1]  = mk(1, 'h1000, 64'h11223344, 8'h0F, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[2]  = mk(1, 'h1004, 64'h55667788_00000000, 8'hF0, 0, 0, 12'h000, 1, 0, 0, 1, 'h0, 8'h00, 64'h0);
      vt[3]  = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h000, 0, 1, 0, 1, 'h1000, 8'hFF, 64'h55667788_11223344);
      vt[4]  = mk(0, 'h0,    64'h0, 8'h00, 0, 1, 12'h000, 0, 1, 0, 1, 'h1000, 8'hFF, 64'h55667788_11223344);
      vt[5]  = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      // address mismatch: second store stalls until the first is issued
      vt[6]  = mk(1, 'h3000, 64'hAA, 8'h01, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[7]  = mk(1, 'h3008, 64'hBB, 8'h01, 0, 0, 12'h000, 0, 0, 0, 1, 'h0, 8'h00, 64'h0);
      vt[8]  = mk(1, 'h3008, 64'hBB, 8'h01, 0, 1, 12'h000, 0, 1, 0, 1, 'h3000, 8'h01, 64'hAA);
      vt[9]  = mk(1, 'h3008, 64'hBB, 8'h01, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[10] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h000, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[11] = mk(0, 'h0,    64'h0, 8'h00, 1, 0, 12'h000, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[12] = mk(0, 'h0,    64'h0, 8'h00, 0, 1, 12'h000, 0, 1, 0, 0, 'h3008, 8'h01, 64'hBB);
      vt[13] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h000, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      // load hazard check against the held entry
      vt[14] = mk(1, 'h4010, 64'h1234, 8'h03, 0, 0, 12'h014, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[15] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h014, 0, 0, 0, 1, 'h0, 8'h00, 64'h0);
      vt[16] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h018, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[17] = mk(0, 'h0,    64'h0, 8'h00, 1, 0, 12'h018, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[18] = mk(0, 'h0,    64'h0, 8'h00, 0, 1, 12'h010, 0, 1, 0, 1, 'h4010, 8'h03, 64'h1234);
      vt[19] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'h010, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      // drain beats a same-dword merge
      vt[20] = mk(1, 'h5000, 64'h01, 8'h01, 0, 0, 12'hFF8, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[21] = mk(1, 'h5001, 64'h0200, 8'h02, 1, 0, 12'hFF8, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[22] = mk(1, 'h5001, 64'h0200, 8'h02, 0, 1, 12'hFF8, 0, 1, 0, 0, 'h5000, 8'h01, 64'h01);
      vt[23] = mk(1, 'h5001, 64'h0200, 8'h02, 0, 0, 12'hFF8, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[24] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'hFF8, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[25] = mk(0, 'h0,    64'h0, 8'h00, 1, 0, 12'hFF8, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[26] = mk(0, 'h0,    64'h0, 8'h00, 0, 1, 12'hFF8, 0, 1, 0, 0, 'h5000, 8'h02, 64'h0200);
      vt[27] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'hFF8, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      // back-to-back merges with no bubble
      vt[28] = mk(1, 'h6000, 64'h11, 8'h01, 0, 0, 12'hFF8, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);
      vt[29] = mk(1, 'h6001, 64'h2200, 8'h02, 0, 0, 12'hFF8, 1, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[30] = mk(1, 'h6002, 64'h330000, 8'h04, 0, 0, 12'hFF8, 1, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[31] = mk(0, 'h0,    64'h0, 8'h00, 1, 0, 12'hFF8, 0, 0, 0, 0, 'h0, 8'h00, 64'h0);
      vt[32] = mk(0, 'h0,    64'h0, 8'h00, 0, 1, 12'hFF8, 0, 1, 0, 0, 'h6000, 8'h07, 64'h332211);
      vt[33] = mk(0, 'h0,    64'h0, 8'h00, 0, 0, 12'hFF8, 1, 0, 1, 0, 'h0, 8'h00, 64'h0);

      // reset state, observed while reset is asserted
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_match", 64'(pmatch), 64'd0);
      chk("rst_req",   64'(dreq.data_req), 64'd0);
      $display("seq reset: ready=%0b empty=%0b match=%0b req=%0b", ready, empty, pmatch, dreq.data_req);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         drive(vt[i].v, vt[i].a, vt[i].d, vt[i].be, vt[i].dr, vt[i].g);
         poff = vt[i].po;
         #1;
         $display("vec %0d: valid=%0b paddr=%h be=%h drain=%0b gnt=%0b -> ready=%0b req=%0b empty=%0b match=%0b",
                  i, valid, paddr, be_in, drain, gnt, ready, dreq.data_req, empty, pmatch);
         chk($sformatf("v%0d_ready", i), 64'(ready), 64'(vt[i].e_ready));
         chk($sformatf("v%0d_req", i),   64'(dreq.data_req), 64'(vt[i].e_req));
         chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vt[i].e_empty));
         chk($sformatf("v%0d_match", i), 64'(pmatch), 64'(vt[i].e_match));
         if (vt[i].e_req) begin
            chk_req($sformatf("v%0d", i), vt[i].e_addr, vt[i].e_be, vt[i].e_wdata);
         end
      end

      // timeout from a single lone store
      @(negedge clk);
      drive(1'b1, 'h2008, 64'h5A, 8'h01, 1'b0, 1'b0);
      poff = 12'h000;
      #1;
      chk("to_accept", 64'(ready), 64'd1);
      wait_req("timeout", TO + 1);

      // a late merge restarts the idle window
      @(negedge clk);
      drive(1'b1, 'h2010, 64'h01, 8'h01, 1'b0, 1'b0);
      #1;
      chk("tm_accept", 64'(ready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1'b0, '0, '0, 8'h00, 1'b0, 1'b0);
         #1;
         chk($sformatf("tm_idle%0d", i), 64'(dreq.data_req), 64'd0);
      end
      @(negedge clk);
      drive(1'b1, 'h2011, 64'h2200, 8'h02, 1'b0, 1'b0);
      #1;
      chk("tm_merge", 64'(ready), 64'd1);
      wait_req("timeout_after_merge", TO + 1);

      // drain in HOLD, then the grant is withheld for five cycles
      @(negedge clk);
      drive(1'b1, 'h7000, 64'hDEADBEEF_00000000, 8'hF0, 1'b0, 1'b0);
      #1;
      chk("ds_accept", 64'(ready), 64'd1);
      @(negedge clk);
      drive(1'b0, '0, '0, 8'h00, 1'b1, 1'b0);
      #1;
      chk("ds_hold_req", 64'(dreq.data_req), 64'd0);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         drain = 1'b0;
         #1;
         chk_req($sformatf("ds_stall%0d", s), 'h7000, 8'hF0, 64'hDEADBEEF_00000000);
         chk($sformatf("ds_stall%0d_ready", s), 64'(ready), 64'd0);
      end
      $display("seq drain_stall: request held through 5 stalled cycles");
      @(negedge clk);
      gnt = 1'b1;
      #1;
      chk_req("ds_gnt", 'h7000, 8'hF0, 64'hDEADBEEF_00000000);
      @(negedge clk);
      gnt = 1'b0;
      #1;
      chk("ds_empty", 64'(empty), 64'd1);
      chk("ds_req_off", 64'(dreq.data_req), 64'd0);

      // full-mask store: minimum latency, then reset while the request is pending
      @(negedge clk);
      drive(1'b1, 'h8000, 64'h01234567_89ABCDEF, 8'hFF, 1'b0, 1'b0);
      poff = 12'h000;
      #1;
      chk("ml_accept", 64'(ready), 64'd1);
      @(negedge clk);
      drive(1'b0, '0, '0, 8'h00, 1'b0, 1'b0);
      #1;
      chk("ml_cycle1_req", 64'(dreq.data_req), 64'd0);
      @(negedge clk);
      #1;
      chk_req("ml_cycle2", 'h8000, 8'hFF, 64'h01234567_89ABCDEF);
      @(negedge clk);
      #1;
      chk("rr_before", 64'(dreq.data_req), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rr_req",   64'(dreq.data_req), 64'd0);
      chk("rr_empty", 64'(empty), 64'd1);
      chk("rr_ready", 64'(ready), 64'd1);
      chk("rr_match", 64'(pmatch), 64'd0);
      $display("seq reset_mid_req: req=%0b empty=%0b without a clock edge", dreq.data_req, empty);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rr_after_empty", 64'(empty), 64'd1);
      chk("rr_after_req",   64'(dreq.data_req), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter MERGE_TIMEOUT, default 8: idle cycles a partially merged entry is held before it is issued to the D$.
REQ-002 SHALL have port clk_i, input, 1: clock; single clock domain.
REQ-003 SHALL have port rst_ni, input, 1: reset; asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1: a committed store is offered by the store buffer.
REQ-005 SHALL have port ready_o, output, 1: the offered store is accepted this cycle.
REQ-006 SHALL have port paddr_i, input, riscv::PLEN: physical address of the offered store.
REQ-007 SHALL have port data_i, input, 64: offered write data, already aligned to its double-word.
REQ-008 SHALL have port be_i, input, 8: byte enables of the offered store.
REQ-009 SHALL have port drain_i, input, 1: fence or AMO request; issue the held entry immediately.
REQ-010 SHALL have port empty_o, output, 1: no entry is held or in flight.
REQ-011 SHALL have port page_offset_i, input, 12: page offset of a load, for the forwarding hazard check.
REQ-012 SHALL have port page_offset_matches_o, output, 1: the held entry overlaps page_offset_i.
REQ-013 SHALL have port req_port_i, input, dcache_req_o_t: D$ response (data_gnt used).
REQ-014 SHALL have port req_port_o, output, dcache_req_i_t: D$ write request.

Function
REQ-015 SHALL hold one entry: dword address (paddr[PLEN-1:3]), 64-bit data, 8-bit be, timeout counter.
REQ-016 SHALL implement states EMPTY, HOLD and REQ.
REQ-017 EMPTY: ready_o=1; on valid_i, SHALL capture paddr, data and be, clear the counter, and go to HOLD.
REQ-018 HOLD: ready_o SHALL be 1 only when valid_i, the dword address matches the held entry, and drain_i=0.
REQ-019 HOLD merge: per byte, data SHALL take data_i where be_i=1, else keep the held byte; be SHALL become be | be_i.
REQ-020 HOLD merge: the counter SHALL clear on every merge, else increment each cycle.
REQ-021 HOLD SHALL go to REQ on any of:
- drain_i;
- valid_i with a non-matching dword address;
- counter equal to MERGE_TIMEOUT-1 with no merge in that cycle;
- merged be equal to 8'hFF.
REQ-022 HOLD SHALL give a same-cycle merge priority over the timeout.
REQ-023 HOLD SHALL give drain_i priority over a merge: the store is not accepted.
REQ-024 REQ: ready_o SHALL be 0 and the request SHALL be driven as follows:
- data_req=1, data_we=1, tag_valid=1, kill_req=0;
- data_size=2'b11, data_be=held be, data_wdata=held data;
- address_index and address_tag split from the held dword address, low 3 bits 0.
REQ-025 REQ SHALL hold all request fields stable until data_gnt, then go to EMPTY in the next cycle.
REQ-026 SHALL give a minimum latency of 2 cycles from acceptance (EMPTY to HOLD to REQ) to data_req.
REQ-027 empty_o SHALL be 1 exactly when the state is EMPTY.
REQ-028 page_offset_matches_o SHALL be 1 when the state is not EMPTY and held paddr[11:3] equals page_offset_i[11:3].
REQ-029 SHALL have no flush input: committed stores are architectural and are never dropped.
REQ-030 Back-to-back stores to the same dword SHALL merge at 1 per cycle with no bubble.

Reset
REQ-031 On rst_ni low, asynchronously, state SHALL become EMPTY and held data, be and counter SHALL become 0.
REQ-032 During reset, outputs SHALL be ready_o=1, empty_o=1, page_offset_matches_o=0, data_req=0.
REQ-033 Reset mid-REQ SHALL abandon the request; the D$ is reset by the same rst_ni.

Structure
REQ-034 dcache_req_i_t, dcache_req_o_t and riscv::PLEN SHALL come from the shared packages (ariane_pkg, riscv).
REQ-035 The MERGE_TIMEOUT default SHALL be a constant in ariane_pkg.
REQ-036 The state enum SHALL be local to the module.
REQ-037 The block SHALL have no sub-module; the byte-merge SHALL be a function in ariane_pkg.

Verification
REQ-038 SHALL cover the byte-merge scenario:
- stimulus: store 0x1000 be=0x0F data=0x11223344, then 0x1004 be=0xF0 data=0x55667788_00000000;
- response: a single D$ write, addr 0x1000, be=0xFF, wdata=0x55667788_11223344.
REQ-039 SHALL cover the timeout scenario:
- stimulus: one store 0x2008 be=0x01, no further traffic;
- response: data_req rises exactly MERGE_TIMEOUT+1 cycles after acceptance.
REQ-040 SHALL cover the address-mismatch scenario:
- stimulus: a store to 0x3000, then a store to 0x3008 on the next cycle;
- response: ready_o=0 for 0x3008; 0x3000 is issued; 0x3008 is accepted the cycle after EMPTY.
REQ-041 SHALL cover the drain and grant-stall scenario:
- stimulus: drain_i=1 in HOLD; data_gnt held low for 5 cycles;
- response: data_req and all request fields stay stable for 5 cycles; empty_o=1 the cycle after the grant.
REQ-042 SHALL cover the hazard-check scenario:
- stimulus: held entry 0x4010, page_offset_i=0x014, then page_offset_i=0x018;
- response: page_offset_matches_o is 1, then 0.
REQ-043 SHALL cover the reset-mid-operation scenario:
- stimulus: rst_ni asserted while in REQ;
- response: data_req=0 and empty_o=1 immediately, without a clock edge.
